// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared types and widths for the enemy formation controller
package enemy_pkg;
    localparam int COORD_W = 10;
    localparam int EXT_W   = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MARCH_R = 3'd1,
        ST_MARCH_L = 3'd2,
        ST_LANDED  = 3'd3,
        ST_CLEARED = 3'd4
    } formation_state_t;
endpackage

// File: rtl/enemy_formation_extent.sv
// rtl/enemy_formation_extent.sv - outermost living columns and lowest living row of the grid
module formation_extent #(
    parameter int ROWS_P = 3,
    parameter int COLS_P = 8
) (
    input  logic [ROWS_P*COLS_P-1:0]   alive_i,
    output logic [$clog2(COLS_P)-1:0]  lcol_o,
    output logic [$clog2(COLS_P)-1:0]  rcol_o,
    output logic [$clog2(ROWS_P)-1:0]  brow_o,
    output logic                       any_o
);
    localparam int ROW_W = $clog2(ROWS_P);
    localparam int COL_W = $clog2(COLS_P);

    logic [COLS_P-1:0] col_any;
    logic [ROWS_P-1:0] row_any;

    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < ROWS_P; r++) begin
            for (int c = 0; c < COLS_P; c++) begin
                if (alive_i[r*COLS_P+c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
        // Scan directions pick the lowest / highest set index respectively
        lcol_o = '0;
        for (int c = COLS_P-1; c >= 0; c--) begin
            if (col_any[c]) lcol_o = COL_W'(c);
        end
        rcol_o = '0;
        for (int c = 0; c < COLS_P; c++) begin
            if (col_any[c]) rcol_o = COL_W'(c);
        end
        brow_o = '0;
        for (int r = 0; r < ROWS_P; r++) begin
            if (row_any[r]) brow_o = ROW_W'(r);
        end
        any_o = |col_any;
    end
endmodule

// File: rtl/enemy_formation.sv
// rtl/enemy_formation.sv - marches the enemy grid as one origin plus alive mask, handles hits
module enemy_formation
    import enemy_pkg::*;
#(
    parameter int ROWS_P       = 3,
    parameter int COLS_P       = 8,
    parameter int SHIP_W_P     = 40,
    parameter int SHIP_H_P     = 20,
    parameter int GAP_X_P      = 10,
    parameter int GAP_Y_P      = 10,
    parameter int LEFT_START_P = 9,
    parameter int TOP_START_P  = 9,
    parameter int SCREEN_W_P   = 640,
    parameter int LAND_Y_P     = 440,
    parameter int STEP_X_P     = 10,
    parameter int STEP_Y_P     = 10,
    parameter int FRAMES_MIN_P = 4
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  start_i,
    input  logic                                  frame_i,
    input  logic                                  hit_valid_i,
    input  logic [$clog2(ROWS_P)-1:0]             hit_row_i,
    input  logic [$clog2(COLS_P)-1:0]             hit_col_i,
    output logic                                  hit_ack_o,
    output logic [COORD_W-1:0]                    origin_x_o,
    output logic [COORD_W-1:0]                    origin_y_o,
    output logic [ROWS_P*COLS_P-1:0]              alive_o,
    output logic [$clog2(ROWS_P*COLS_P+1)-1:0]    alive_count_o,
    output logic                                  landed_o,
    output logic                                  cleared_o
);
    localparam int N     = ROWS_P * COLS_P;
    localparam int ROW_W = $clog2(ROWS_P);
    localparam int COL_W = $clog2(COLS_P);
    localparam int CNT_W = $clog2(N + 1);
    localparam int TMR_W = $clog2(FRAMES_MIN_P + N + 1);

    localparam logic [EXT_W-1:0]   PITCH_X  = EXT_W'(SHIP_W_P + GAP_X_P);
    localparam logic [EXT_W-1:0]   PITCH_Y  = EXT_W'(SHIP_H_P + GAP_Y_P);
    localparam logic [EXT_W-1:0]   SHIP_W_E = EXT_W'(SHIP_W_P);
    localparam logic [EXT_W-1:0]   SHIP_H_E = EXT_W'(SHIP_H_P);
    localparam logic [EXT_W-1:0]   STEP_X_E = EXT_W'(STEP_X_P);
    localparam logic [EXT_W-1:0]   SCREEN_E = EXT_W'(SCREEN_W_P);
    localparam logic [EXT_W-1:0]   LAND_E   = EXT_W'(LAND_Y_P);
    localparam logic [COORD_W-1:0] STEP_X_C = COORD_W'(STEP_X_P);
    localparam logic [COORD_W-1:0] STEP_Y_C = COORD_W'(STEP_Y_P);
    localparam logic [COORD_W-1:0] LEFT_C   = COORD_W'(LEFT_START_P);
    localparam logic [COORD_W-1:0] TOP_C    = COORD_W'(TOP_START_P);
    localparam logic [TMR_W-1:0]   FMIN_M1  = TMR_W'(FRAMES_MIN_P - 1);

    formation_state_t   state_q, state_d;
    logic [COORD_W-1:0] origin_x_q, origin_x_d, origin_y_q, origin_y_d;
    logic [N-1:0]       alive_q, alive_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               ack_q, ack_d;

    logic [COL_W-1:0]   lcol, rcol;
    logic [ROW_W-1:0]   brow;
    logic               any_alive;

    formation_extent #(.ROWS_P(ROWS_P), .COLS_P(COLS_P)) u_extent (
        .alive_i (alive_q),
        .lcol_o  (lcol),
        .rcol_o  (rcol),
        .brow_o  (brow),
        .any_o   (any_alive)
    );

    logic             marching, tick, landing, hit_live;
    logic [TMR_W-1:0] period_m1;
    logic [EXT_W-1:0] right_edge, left_edge, bottom;
    logic [N-1:0]     hit_mask;

    // Extent and period come from the pre-hit mask so a same-cycle hit cannot alter this move
    assign marching   = (state_q == ST_MARCH_R) || (state_q == ST_MARCH_L);
    assign period_m1  = FMIN_M1 + TMR_W'(count_q);
    assign tick       = marching && frame_i && (timer_q >= period_m1);
    assign right_edge = EXT_W'(origin_x_q) + EXT_W'(rcol) * PITCH_X + SHIP_W_E;
    assign left_edge  = EXT_W'(origin_x_q) + EXT_W'(lcol) * PITCH_X;
    assign bottom     = EXT_W'(origin_y_q) + EXT_W'(brow) * PITCH_Y + SHIP_H_E;
    assign landing    = marching && any_alive && (bottom >= LAND_E);

    always_comb begin
        hit_mask = '0;
        for (int r = 0; r < ROWS_P; r++) begin
            for (int c = 0; c < COLS_P; c++) begin
                if (hit_row_i == ROW_W'(r) && hit_col_i == COL_W'(c)) hit_mask[r*COLS_P+c] = 1'b1;
            end
        end
    end

    assign hit_live = marching && hit_valid_i && |(hit_mask & alive_q);

    always_comb begin
        state_d    = state_q;
        origin_x_d = origin_x_q;
        origin_y_d = origin_y_q;
        alive_d    = alive_q;
        count_d    = count_q;
        timer_d    = timer_q;
        ack_d      = 1'b0;
        if (start_i && !marching) begin
            state_d    = ST_MARCH_R;
            origin_x_d = LEFT_C;
            origin_y_d = TOP_C;
            alive_d    = '1;
            count_d    = CNT_W'(N);
            timer_d    = '0;
        end else if (marching) begin
            if (frame_i) timer_d = tick ? '0 : timer_q + 1'b1;
            if (tick && !landing) begin
                if (state_q == ST_MARCH_R) begin
                    if (right_edge + STEP_X_E > SCREEN_E) begin
                        origin_y_d = origin_y_q + STEP_Y_C;
                        state_d    = ST_MARCH_L;
                    end else begin
                        origin_x_d = origin_x_q + STEP_X_C;
                    end
                end else begin
                    if (left_edge < STEP_X_E) begin
                        origin_y_d = origin_y_q + STEP_Y_C;
                        state_d    = ST_MARCH_R;
                    end else begin
                        origin_x_d = origin_x_q - STEP_X_C;
                    end
                end
            end
            if (hit_live) begin
                alive_d = alive_q & ~hit_mask;
                count_d = count_q - 1'b1;
                ack_d   = 1'b1;
            end
            if (landing) state_d = ST_LANDED;
            if (hit_live && count_q == CNT_W'(1)) state_d = ST_CLEARED;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            origin_x_q <= LEFT_C;
            origin_y_q <= TOP_C;
            alive_q    <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            origin_x_q <= origin_x_d;
            origin_y_q <= origin_y_d;
            alive_q    <= alive_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            ack_q      <= ack_d;
        end
    end

    assign hit_ack_o     = ack_q;
    assign origin_x_o    = origin_x_q;
    assign origin_y_o    = origin_y_q;
    assign alive_o       = alive_q;
    assign alive_count_o = count_q;
    assign landed_o      = (state_q == ST_LANDED);
    assign cleared_o     = (state_q == ST_CLEARED);
endmodule

// File: tb/tb_enemy_formation.sv
// tb/tb_enemy_formation.sv - scoreboard bench for enemy_formation with default parameters
module tb_enemy_formation;
    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic        frame_i = 1'b0;
    logic        hit_valid_i = 1'b0;
    logic [1:0]  hit_row_i = '0;
    logic [2:0]  hit_col_i = '0;
    logic        hit_ack_o;
    logic [9:0]  origin_x_o, origin_y_o;
    logic [23:0] alive_o;
    logic [4:0]  alive_count_o;
    logic        landed_o, cleared_o;

    enemy_formation dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .start_i       (start_i),
        .frame_i       (frame_i),
        .hit_valid_i   (hit_valid_i),
        .hit_row_i     (hit_row_i),
        .hit_col_i     (hit_col_i),
        .hit_ack_o     (hit_ack_o),
        .origin_x_o    (origin_x_o),
        .origin_y_o    (origin_y_o),
        .alive_o       (alive_o),
        .alive_count_o (alive_count_o),
        .landed_o      (landed_o),
        .cleared_o     (cleared_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [9:0]  ox;
        logic [9:0]  oy;
        logic [23:0] alive;
        logic [4:0]  cnt;
        logic        ack;
        logic        landed;
        logic        cleared;
    } snap_t;

    localparam int M_IDLE = 0, M_R = 1, M_L = 2, M_LAND = 3, M_CLR = 4;

    snap_t       sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_st, m_x, m_y, m_cnt, m_tmr;
    logic [23:0] m_alive;
    logic        m_ack;

    task automatic model_reset();
        m_st = M_IDLE; m_x = 9; m_y = 9; m_cnt = 0; m_tmr = 0;
        m_alive = '0; m_ack = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic fr, input logic hv, input int r, input int c);
        int lc, rc, br, nst;
        logic tk, land;
        snap_t s;
        m_ack = 1'b0;
        if (st && (m_st == M_IDLE || m_st == M_LAND || m_st == M_CLR)) begin
            m_st = M_R; m_x = 9; m_y = 9; m_alive = 24'hFF_FFFF; m_cnt = 24; m_tmr = 0;
        end else if (m_st == M_R || m_st == M_L) begin
            lc = 99; rc = -1; br = -1;
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 8; cc++)
                    if (m_alive[rr*8+cc]) begin
                        if (cc < lc) lc = cc;
                        if (cc > rc) rc = cc;
                        if (rr > br) br = rr;
                    end
            tk = fr && (m_tmr >= 4 + m_cnt - 1);
            if (fr) m_tmr = tk ? 0 : m_tmr + 1;
            land = (br >= 0) && (m_y + br*30 + 20 >= 440);
            nst = m_st;
            if (tk && !land) begin
                if (m_st == M_R) begin
                    if (m_x + rc*50 + 40 + 10 > 640) begin m_y += 10; nst = M_L; end
                    else m_x += 10;
                end else begin
                    if (m_x + lc*50 < 10) begin m_y += 10; nst = M_R; end
                    else m_x -= 10;
                end
            end
            if (hv && r < 3 && c < 8) begin
                if (m_alive[r*8+c]) begin
                    m_alive[r*8+c] = 1'b0; m_cnt--; m_ack = 1'b1;
                end
            end
            if (land) nst = M_LAND;
            if (m_cnt == 0) nst = M_CLR;
            m_st = nst;
        end
        s = {10'(m_x), 10'(m_y), m_alive, 5'(m_cnt), m_ack, (m_st == M_LAND), (m_st == M_CLR)};
        sb_q.push_back(s);
    endtask

    task automatic cycle(input logic st, input logic fr, input logic hv, input logic [1:0] r, input logic [2:0] c);
        snap_t exp_s, got_s;
        start_i = st; frame_i = fr; hit_valid_i = hv; hit_row_i = r; hit_col_i = c;
        model_step(st, fr, hv, int'(r), int'(c));
        @(posedge clk_i); #1;
        start_i = 1'b0; frame_i = 1'b0; hit_valid_i = 1'b0;
        exp_s = sb_q.pop_front();
        got_s = {origin_x_o, origin_y_o, alive_o, alive_count_o, hit_ack_o, landed_o, cleared_o};
        n_checks++;
        if (got_s !== exp_s) begin
            n_errors++;
            if (n_errors <= 20)
                $display("FAIL scoreboard t=%0t: got x=%0d y=%0d alive=%h cnt=%0d ack=%b land=%b clr=%b, expected x=%0d y=%0d alive=%h cnt=%0d ack=%b land=%b clr=%b",
                         $time, got_s.ox, got_s.oy, got_s.alive, got_s.cnt, got_s.ack, got_s.landed, got_s.cleared,
                         exp_s.ox, exp_s.oy, exp_s.alive, exp_s.cnt, exp_s.ack, exp_s.landed, exp_s.cleared);
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 2'd0, 3'd0);
    endtask

    task automatic hit(input logic [1:0] r, input logic [2:0] c);
        cycle(1'b0, 1'b0, 1'b1, r, c);
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        start_i = 1'b0; frame_i = 1'b0; hit_valid_i = 1'b0;
        model_reset();
        sb_q.delete();
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
    endtask

    task automatic chk(input string name, input int got, input int exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp_v);
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_origin_x", int'(origin_x_o), 9);
        chk("reset_origin_y", int'(origin_y_o), 9);
        chk("reset_alive", int'(alive_o), 0);
        chk("reset_count", int'(alive_count_o), 0);
        chk("reset_flags", int'({hit_ack_o, landed_o, cleared_o}), 0);
    endtask

    task automatic test_first_move();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        chk("start_alive", int'(alive_o), 24'hFF_FFFF);
        chk("start_count", int'(alive_count_o), 24);
        frames(27);
        chk("no_move_before_28", int'(origin_x_o), 9);
        frames(1);
        chk("first_move_x", int'(origin_x_o), 19);
    endtask

    task automatic test_march_bounce();
        frames(24 * 28);
        chk("bounce_x", int'(origin_x_o), 249);
        chk("bounce_y", int'(origin_y_o), 19);
        frames(28);
        chk("march_left_x", int'(origin_x_o), 239);
    endtask

    task automatic test_kill_column();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        for (int r = 0; r < 3; r++) begin
            hit(2'(r), 3'd7);
            chk("col7_ack", int'(hit_ack_o), 1);
        end
        chk("col7_count", int'(alive_count_o), 21);
        frames(29 * 25);
        chk("col6_edge_x", int'(origin_x_o), 299);
        chk("col6_edge_y", int'(origin_y_o), 9);
        frames(25);
        chk("col6_bounce_y", int'(origin_y_o), 19);
        chk("col6_bounce_x", int'(origin_x_o), 299);
    endtask

    task automatic test_bad_hits();
        hit(2'd0, 3'd7);
        chk("dead_hit_ack", int'(hit_ack_o), 0);
        chk("dead_hit_count", int'(alive_count_o), 21);
        hit(2'd3, 3'd0);
        chk("oor_hit_ack", int'(hit_ack_o), 0);
        chk("oor_hit_alive", int'(alive_o), 24'h7F_7F7F);
    endtask

    task automatic test_hit_with_tick();
        for (int k = 0; k < 100 && m_tmr != 4 + m_cnt - 1; k++) frames(1);
        chk("tick_align_timeout", m_tmr, 4 + m_cnt - 1);
        cycle(1'b0, 1'b1, 1'b1, 2'd1, 3'd3);
        chk("hit_tick_x", int'(origin_x_o), 289);
        chk("hit_tick_ack", int'(hit_ack_o), 1);
        chk("hit_tick_count", int'(alive_count_o), 20);
        frames(30);
    endtask

    task automatic test_period_shrink();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        frames(20);
        for (int c = 0; c < 8; c++) hit(2'd0, 3'(c));
        hit(2'd1, 3'd0);
        hit(2'd1, 3'd1);
        chk("shrink_count", int'(alive_count_o), 14);
        chk("shrink_no_move_yet", int'(origin_x_o), 9);
        frames(1);
        chk("shrink_forced_tick", int'(origin_x_o), 19);
    endtask

    task automatic march_to_landing(input string tag);
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 8; c++)
                if (!(r == 2 && c == 0)) hit(2'(r), 3'(c));
        for (int k = 0; k < 20000 && m_y < 360; k++) frames(1);
        chk({tag, "_descent_y"}, m_y, 369);
        chk({tag, "_not_yet_landed"}, int'(landed_o), 0);
    endtask

    task automatic test_landed();
        march_to_landing("land");
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        chk("landed_flag", int'(landed_o), 1);
        chk("landed_not_cleared", int'(cleared_o), 0);
        frames(12);
        chk("landed_frozen_x", int'(origin_x_o), 9);
        chk("landed_frozen_y", int'(origin_y_o), 369);
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        chk("restart_from_landed", int'({landed_o, alive_count_o}), 24);
    endtask

    task automatic test_clear_on_land();
        march_to_landing("clear");
        hit(2'd2, 3'd0);
        chk("clear_flag", int'(cleared_o), 1);
        chk("clear_beats_land", int'(landed_o), 0);
        chk("clear_count", int'(alive_count_o), 0);
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        chk("restart_alive", int'(alive_o), 24'hFF_FFFF);
        chk("restart_origin", int'({origin_x_o, origin_y_o}), (9 << 10) | 9);
        chk("restart_cleared", int'(cleared_o), 0);
    endtask

    task automatic test_reset_mid_march();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
        frames(40);
        hit(2'd0, 3'd0);
        #3 reset_n_i = 1'b0;
        #1;
        chk("async_reset_origin", int'({origin_x_o, origin_y_o}), (9 << 10) | 9);
        chk("async_reset_alive", int'(alive_o), 0);
        chk("async_reset_count_flags", int'({alive_count_o, hit_ack_o, landed_o, cleared_o}), 0);
        model_reset();
        sb_q.delete();
        @(posedge clk_i); #1 reset_n_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_march_bounce();
        test_kill_column();
        test_bad_hits();
        test_hit_with_tick();
        test_period_shrink();
        test_landed();
        test_clear_on_land();
        test_reset_mid_march();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
